sync_fifo_prog: RTL and testbench
=================================

Name: sync_fifo_prog

Overview:
Single-clock, parametrised successor to the team's async FIFO, used for same-domain buffering between datapath stages. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow error flags, a synchronous flush, and a selectable first-word-fall-through (FWFT) read mode.

Parameters:
DATA_WIDTH, 8, word width in bits
DEPTH, 16, number of entries; power of two, at least 4
AFULL_THRESH, DEPTH-2, almost_full asserts when count >= this value (1..DEPTH)
AEMPTY_THRESH, 2, almost_empty asserts when count <= this value (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of contents and error flags
w_en  in  1  write request
data_in  in  DATA_WIDTH  write data
r_en  in  1  read (pop) request
data_out  out  DATA_WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AFULL_THRESH
almost_empty  out  1  count <= AEMPTY_THRESH
count  out  PTR_WIDTH+1  occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty

Behaviour:
- PTR_WIDTH = clog2(DEPTH). Write and read pointers are PTR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
- Reset (rst=1, asynchronous): pointers = 0, count = 0, data_out = 0, overflow = 0, underflow = 0. Outputs after reset: empty = 1, full = 0, almost_empty = 1, almost_full = 0.
- Write is accepted iff w_en && !full. An accepted write stores data_in at wptr and increments wptr.
- Read is accepted iff r_en && !empty. An accepted read increments rptr.
- full, empty, almost_* and count are decoded from the registered count, so they change on the same edge as the accepted operation. There is no combinational path from w_en/r_en to any flag.
- Simultaneous accepted write and read: count is unchanged and both pointers advance.
- Full with w_en && r_en: the read is accepted, the write is rejected (full gates on the current count), and overflow sets.
- Empty with w_en && r_en: the write is accepted, the read is rejected, and underflow sets. Count goes to 1.
- overflow and underflow stay set until rst or flush.
- Standard mode (FWFT=0): on an accepted read, data_out <= mem[rptr] at the same edge (1-cycle read latency). data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1): data_out = mem[rptr] whenever !empty and is 0 when empty. The first write becomes visible the cycle after it is accepted, when empty deasserts. r_en acknowledges (pops) the current word.
- flush (synchronous, priority over w_en/r_en in the same cycle): pointers, count and error flags clear to 0; data_out clears to 0. Memory contents are not cleared.
- rst asserted mid-operation: all state is cleared immediately, regardless of any in-flight w_en/r_en.
- Memory array is not reset. It is never read while empty in standard mode, and is masked in FWFT mode.

Decomposition:
- Shared package: a clog2 helper function, PTR_WIDTH/CNT_WIDTH derivation, and a FIFO mode constant encoding (MODE_STD=0, MODE_FWFT=1), reusable by the async FIFO.
- One sub-module, fifo_mem: a DEPTH x DATA_WIDTH simple dual-port array with a synchronous write port and an asynchronous read port.
- The top level holds the pointers, count, flags and the output register/mux.

Test Plan:
1. Reset then idle, DEPTH=16, FWFT=0 -> empty=1, almost_empty=1, count=0, full=0, overflow=0, underflow=0, data_out=0.
2. Write 0x11..0x15 (5 words), then read 5 in FWFT=0 -> count steps 1..5 then 4..0; each data_out appears 1 cycle after its accepted r_en, in order 0x11..0x15; almost_empty deasserts at count=3 and reasserts at count=2.
3. Write 17 words with DEPTH=16, AFULL_THRESH=14 -> almost_full rises when count=14, full rises at count=16, 17th write dropped, overflow=1 and sticky; drain all 16 words -> values match writes 1..16 in order, including across pointer wrap.
4. While empty, assert r_en together with w_en=0xA5 -> underflow=1, count=1; next read returns 0xA5. While full, assert w_en with r_en -> count goes to 15, overflow=1.
5. FWFT=1: write 0x3C -> data_out=0x3C one cycle later with no r_en; pop -> empty=1, data_out=0. Streaming simultaneous r/w for 30 cycles -> count constant, data order preserved.
6. Fill to 8, pulse flush concurrent with w_en -> count=0, empty=1, flags cleared, write ignored. Assert rst asynchronously mid-burst (between clock edges) -> outputs reach reset values before the next clk edge.

Source files
------------

// File: rtl/sync_fifo_prog_pkg.sv
// Shared FIFO helpers: pointer/count width derivation and read-mode encoding.
package sync_fifo_prog_pkg;

  localparam int unsigned MODE_STD  = 0;
  localparam int unsigned MODE_FWFT = 1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

  // Occupancy needs one extra bit so that DEPTH itself is representable.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable thresholds, occupancy count, sticky
// error flags, synchronous flush and optional first-word-fall-through reads.
module sync_fifo_prog
  import sync_fifo_prog_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 2,
  parameter int unsigned FWFT          = MODE_STD
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        w_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        r_en,
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [cnt_width(DEPTH)-1:0] count,
  output logic                        overflow,
  output logic                        underflow
);

  localparam int unsigned PTR_WIDTH = clog2(DEPTH);
  localparam int unsigned CNT_WIDTH = PTR_WIDTH + 1;

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_prog: DEPTH must be a power of two >= 4");
  end

  logic [PTR_WIDTH-1:0]  wptr;
  logic [PTR_WIDTH-1:0]  rptr;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [CNT_WIDTH-1:0]  count_nxt;
  logic [DATA_WIDTH-1:0] rd_data;

  // Acceptance gates on the registered flags only; flush overrides both.
  always_comb begin
    wr_acc    = w_en && !full;
    rd_acc    = r_en && !empty;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      count_nxt = count + CNT_WIDTH'(1);
    end else if (rd_acc && !wr_acc) begin
      count_nxt = count - CNT_WIDTH'(1);
    end
  end

  // Flags are registered from the next count so they move with the operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      count        <= count_nxt;
      full         <= (count_nxt == CNT_WIDTH'(DEPTH));
      empty        <= (count_nxt == '0);
      almost_full  <= (count_nxt >= CNT_WIDTH'(AFULL_THRESH));
      almost_empty <= (count_nxt <= CNT_WIDTH'(AEMPTY_THRESH));
      if (flush) begin
        wptr      <= '0;
        rptr      <= '0;
        overflow  <= 1'b0;
        underflow <= 1'b0;
      end else begin
        if (wr_acc) wptr <= wptr + PTR_WIDTH'(1);
        if (rd_acc) rptr <= rptr + PTR_WIDTH'(1);
        overflow  <= overflow  | (w_en && full);
        underflow <= underflow | (r_en && empty);
      end
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc && !flush),
    .waddr (wptr),
    .wdata (data_in),
    .raddr (rptr),
    .rdata (rd_data)
  );

  if (FWFT == MODE_FWFT) begin : g_fwft
    // Head word is presented directly; masked so stale memory never leaks out.
    assign data_out = empty ? '0 : rd_data;
  end else begin : g_std
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_out <= '0;
      end else if (flush) begin
        data_out <= '0;
      end else if (rd_acc) begin
        data_out <= rd_data;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Scoreboard bench: one stimulus stream drives a standard-mode and an FWFT-mode
// instance; a queue model predicts flags, count and read data.
module tb_sync_fifo_prog;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;
  localparam int CW    = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          w_en = 1'b0;
  logic          r_en = 1'b0;
  logic [DW-1:0] data_in = '0;

  logic [DW-1:0] s_dout, f_dout;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] s_count, f_count;

  logic [DW-1:0] mdl[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] hold = '0;
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            clr_seen = 0;
  int            checks = 0;
  int            errors = 0;

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_prog #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AF), .AEMPTY_THRESH(AE), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .data_in(data_in), .r_en(r_en),
    .data_out(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d time=%0t", nm, act, exp, $time);
    end
  endfunction

  // Reference behaviour of one clock edge, evaluated on pre-edge occupancy.
  function automatic void model_step(input bit w, input logic [DW-1:0] d, input bit r,
                                     input bit f);
    int n;
    n = mdl.size();
    if (f) begin
      mdl.delete();
      m_ovf = 0;
      m_unf = 0;
      clr_seen = 1;
    end else begin
      if (w && n == DEPTH) m_ovf = 1;
      if (r && n == 0) m_unf = 1;
      if (r && n != 0) exp_q.push_back(mdl.pop_front());
      if (w && n != DEPTH) mdl.push_back(d);
    end
  endfunction

  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r, input bit f);
    w_en = w;
    data_in = d;
    r_en = r;
    flush = f;
    @(posedge clk);
    if (!rst) model_step(w, d, r, f);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 0, 0);
  endtask

  // Reset lands between edges; outputs must clear before the next rising edge.
  task automatic async_reset();
    #1;
    rst = 1'b1;
    mdl.delete();
    m_ovf = 0;
    m_unf = 0;
    clr_seen = 1;
    #1;
    chk("async_rst_count", int'(s_count), 0);
    chk("async_rst_empty", int'(s_empty), 1);
    chk("async_rst_full", int'(s_full), 0);
    chk("async_rst_ovf", int'(s_ovf), 0);
    chk("async_rst_unf", int'(s_unf), 0);
    chk("async_rst_std_dout", int'(s_dout), 0);
    chk("async_rst_fwft_dout", int'(f_dout), 0);
    chk("async_rst_fwft_count", int'(f_count), 0);
    w_en = 0;
    r_en = 0;
    flush = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: retires one scoreboard entry per presented read, checks status.
  always @(negedge clk) begin
    int n;
    logic [DW-1:0] f_exp;
    if (clr_seen) begin
      hold = '0;
      exp_q.delete();
      clr_seen = 0;
    end
    if (exp_q.size() > 0) hold = exp_q.pop_front();
    n = mdl.size();
    f_exp = (n > 0) ? mdl[0] : '0;
    chk("std_data_out", int'(s_dout), int'(hold));
    chk("fwft_data_out", int'(f_dout), int'(f_exp));
    chk("std_count", int'(s_count), n);
    chk("fwft_count", int'(f_count), n);
    chk("std_full", int'(s_full), int'(n == DEPTH));
    chk("std_empty", int'(s_empty), int'(n == 0));
    chk("std_almost_full", int'(s_af), int'(n >= AF));
    chk("std_almost_empty", int'(s_ae), int'(n <= AE));
    chk("std_overflow", int'(s_ovf), int'(m_ovf));
    chk("std_underflow", int'(s_unf), int'(m_unf));
    chk("fwft_full", int'(f_full), int'(n == DEPTH));
    chk("fwft_empty", int'(f_empty), int'(n == 0));
    chk("fwft_overflow", int'(f_ovf), int'(m_ovf));
    chk("fwft_underflow", int'(f_unf), int'(m_unf));
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    // 5-word write then drain
    for (int i = 0; i < 5; i++) cycle(1, 8'(8'h11 + i), 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, '0, 1, 0);
    idle(2);

    // Overfill by one, then drain across the pointer wrap
    for (int i = 0; i < 17; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 16; i++) cycle(0, '0, 1, 0);
    idle(1);

    // Read+write while empty, then write+read while full
    cycle(1, 8'hA5, 1, 0);
    cycle(0, '0, 1, 0);
    idle(1);
    for (int i = 0; i < 16; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'hEE, 1, 0);
    idle(1);
    while (mdl.size() > 0) cycle(0, '0, 1, 0);

    // Fall-through visibility and streaming
    cycle(1, 8'h3C, 0, 0);
    idle(2);
    cycle(0, '0, 1, 0);
    idle(1);
    cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < 30; i++) cycle(1, 8'($urandom), 1, 0);
    idle(1);

    // Flush with a concurrent write, then asynchronous reset mid-burst
    cycle(0, '0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(1, 8'h77, 0, 1);
    idle(2);
    for (int i = 0; i < 6; i++) cycle(1, 8'($urandom), (i > 2), 0);
    async_reset();
    idle(2);

    // Random traffic with occasional flushes
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 2);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
